// File: rtl/cpu_fetch_s.sv
// Instruction fetch stage: one outstanding IL1 request, registered output plus a one-entry skid.
// Ack data reaches fet_valid one cycle later; stall holds the output and parks one extra word in the skid.
module cpu_fetch_s #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        fet_clk,
    input  logic        fet_rst_n,
    output logic        fet_il1_req,
    output logic [31:0] fet_il1_addr,
    input  logic        fet_il1_ack,
    input  logic [31:0] fet_il1_data,
    input  logic        fet_stall,
    input  logic        fet_kill,
    input  logic [31:0] fet_redirect_pc,
    output logic [31:0] fet_inst,
    output logic [31:0] fet_pc,
    output logic [31:0] fet_pc_4,
    output logic        fet_valid
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FULL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic [31:0] r_pc_4;
    logic        r_skid_vld;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic [31:0] r_redir;

    state_t      w_state_nxt;
    logic        w_req_nxt;
    logic [31:0] w_addr_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_skid_vld_nxt;
    logic [31:0] w_skid_inst_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic [31:0] w_redir_nxt;

    logic        w_ack;
    logic        w_out_free;
    logic [31:0] w_redir_al;

    // An ack only counts against a request we are actually driving.
    assign w_ack      = fet_il1_ack & r_req;
    assign w_out_free = ~r_valid | ~fet_stall;
    assign w_redir_al = fet_redirect_pc & ~32'd3;

    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_addr_nxt      = r_addr;
        w_valid_nxt     = r_valid;
        w_inst_nxt      = r_inst;
        w_pc_nxt        = r_pc;
        w_skid_vld_nxt  = r_skid_vld;
        w_skid_inst_nxt = r_skid_inst;
        w_skid_pc_nxt   = r_skid_pc;
        w_redir_nxt     = r_redir;

        if (fet_kill) begin
            w_valid_nxt    = 1'b0;
            w_inst_nxt     = NOP_INST;
            w_skid_vld_nxt = 1'b0;
            if (r_req && !fet_il1_ack) begin
                w_state_nxt = S_FLUSH;
                w_redir_nxt = w_redir_al;
            end else begin
                w_state_nxt = S_RUN;
                w_addr_nxt  = w_redir_al;
                w_req_nxt   = 1'b1;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    w_req_nxt = 1'b1;
                    if (w_ack) begin
                        w_addr_nxt = r_addr + 32'd4;
                        if (w_out_free) begin
                            w_valid_nxt = 1'b1;
                            w_inst_nxt  = fet_il1_data;
                            w_pc_nxt    = r_addr;
                        end else begin
                            w_skid_vld_nxt  = 1'b1;
                            w_skid_inst_nxt = fet_il1_data;
                            w_skid_pc_nxt   = r_addr;
                            w_state_nxt     = S_FULL;
                            w_req_nxt       = 1'b0;
                        end
                    end else if (w_out_free) begin
                        w_valid_nxt = 1'b0;
                        w_inst_nxt  = NOP_INST;
                    end
                end
                S_FULL: begin
                    w_req_nxt = 1'b0;
                    if (!fet_stall || !r_skid_vld) begin
                        w_valid_nxt    = r_skid_vld;
                        w_inst_nxt     = r_skid_vld ? r_skid_inst : NOP_INST;
                        w_pc_nxt       = r_skid_vld ? r_skid_pc : r_pc;
                        w_skid_vld_nxt = 1'b0;
                        w_state_nxt    = S_RUN;
                        w_req_nxt      = 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (w_ack) begin
                        w_state_nxt = S_RUN;
                        w_addr_nxt  = r_redir;
                        w_req_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge fet_clk or negedge fet_rst_n) begin
        if (!fet_rst_n) begin
            r_state     <= S_RUN;
            r_req       <= 1'b0;
            r_addr      <= RESET_PC;
            r_valid     <= 1'b0;
            r_inst      <= NOP_INST;
            r_pc        <= RESET_PC;
            r_pc_4      <= RESET_PC + 32'd4;
            r_skid_vld  <= 1'b0;
            r_skid_inst <= NOP_INST;
            r_skid_pc   <= RESET_PC;
            r_redir     <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_valid     <= w_valid_nxt;
            r_inst      <= w_inst_nxt;
            r_pc        <= w_pc_nxt;
            r_pc_4      <= w_pc_nxt + 32'd4;
            r_skid_vld  <= w_skid_vld_nxt;
            r_skid_inst <= w_skid_inst_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
            r_redir     <= w_redir_nxt;
        end
    end

    assign fet_il1_req  = r_req;
    assign fet_il1_addr = r_addr;
    assign fet_valid    = r_valid;
    assign fet_inst     = r_inst;
    assign fet_pc       = r_pc;
    assign fet_pc_4     = r_pc_4;

endmodule
